// File: rtl/modem_pkg.sv
// Shared types and default constants for the transmit framer.
// The FSM state encoding lives here so the framer and related blocks agree on it.
package modem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC,
        ST_FETCH,
        ST_LOAD,
        ST_PAYLOAD,
        ST_CW,
        ST_DONE
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE_DEF = 8'hAA;
    localparam logic [15:0] SYNC_WORD_DEF     = 16'h2DD4;
    localparam int          RAM_DEPTH_DEF     = 1000;

    // Wide enough for 1000 bytes x 8 bits of CW without wrapping.
    localparam int CNT_W = 13;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/bit_shifter.sv
// 8-bit parallel-load, MSB-first shift register shared by all bit-sending states.
// A load takes priority over a shift in the same cycle.
module bit_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       msb
);

    logic [7:0] data_q;
    logic [7:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {data_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[7];

endmodule

// File: rtl/tx_framer.sv
// Serialises preamble, sync word and RAM payload (or a CW burst) onto a
// valid/ready bit stream; one shifter feeds every bit-sending state.
module tx_framer
    import modem_pkg::*;
#(
    parameter int          PREAMBLE_BYTES = 4,
    parameter logic [7:0]  PREAMBLE_BYTE  = PREAMBLE_BYTE_DEF,
    parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEF,
    parameter int          RAM_DEPTH      = RAM_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_transmit,
    input  logic [9:0] i_msg_length,
    input  logic       i_reg_cw,
    input  logic [7:0] i_ram_data,
    output logic       o_rd,
    output logic [9:0] o_ram_addr,
    output logic       o_bit,
    output logic       o_bit_valid,
    input  logic       i_bit_ready,
    output logic       o_cw_en,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam logic [9:0] DEPTH_L  = 10'(RAM_DEPTH);
    localparam cnt_t       PRE_LAST = cnt_t'(PREAMBLE_BYTES * 8 - 1);

    state_t     state_q, state_d;
    logic [9:0] len_q, len_d;
    logic       cw_q, cw_d;
    cnt_t       cnt_q, cnt_d;
    logic [9:0] idx_q, idx_d;

    logic       sh_load, sh_shift, sh_msb;
    logic [7:0] sh_din;
    logic       xfer;
    logic [9:0] len_clamped;
    logic [9:0] next_idx;
    cnt_t       cw_last;

    bit_shifter u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    assign xfer        = o_bit_valid & i_bit_ready;
    assign len_clamped = (i_msg_length > DEPTH_L) ? DEPTH_L : i_msg_length;
    assign next_idx    = idx_q + 10'd1;
    assign cw_last     = cnt_t'({len_q, 3'b000}) - cnt_t'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cw_q    <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cw_d     = cw_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = PREAMBLE_BYTE;
        unique case (state_q)
            ST_IDLE: begin
                if (i_transmit) begin
                    len_d   = len_clamped;
                    cw_d    = i_reg_cw;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sh_load = 1'b1;
                    if (i_reg_cw) begin
                        state_d = ST_CW;
                    end else if (PREAMBLE_BYTES == 0) begin
                        sh_din  = SYNC_WORD[15:8];
                        state_d = ST_SYNC;
                    end else begin
                        state_d = ST_PREAMBLE;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (xfer) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = '0;
                        sh_load = 1'b1;
                        sh_din  = SYNC_WORD[15:8];
                        state_d = ST_SYNC;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                        if (cnt_q[2:0] == 3'd7) begin
                            sh_load = 1'b1;
                        end else begin
                            sh_shift = 1'b1;
                        end
                    end
                end
            end
            ST_SYNC: begin
                if (xfer) begin
                    if (cnt_q == cnt_t'(15)) begin
                        cnt_d   = '0;
                        state_d = (len_q != '0) ? ST_FETCH : ST_DONE;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                        if (cnt_q == cnt_t'(7)) begin
                            sh_load = 1'b1;
                            sh_din  = SYNC_WORD[7:0];
                        end else begin
                            sh_shift = 1'b1;
                        end
                    end
                end
            end
            ST_FETCH: state_d = ST_LOAD;
            // RAM data arrives the cycle after the read strobe.
            ST_LOAD: begin
                sh_load = 1'b1;
                sh_din  = i_ram_data;
                state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (cnt_q[2:0] == 3'd7) begin
                        cnt_d   = '0;
                        idx_d   = next_idx;
                        state_d = (next_idx < len_q) ? ST_FETCH : ST_DONE;
                    end else begin
                        cnt_d    = cnt_q + cnt_t'(1);
                        sh_shift = 1'b1;
                    end
                end
            end
            ST_CW: begin
                if (len_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (xfer) begin
                    if (cnt_q == cw_last) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            // cnt_q==0 marks the first DONE cycle, which carries the pulse.
            ST_DONE: begin
                cnt_d = cnt_t'(1);
                if (!i_transmit) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rd        = 1'b0;
        o_ram_addr  = '0;
        o_bit       = 1'b0;
        o_bit_valid = 1'b0;
        o_cw_en     = 1'b0;
        o_tx_done   = 1'b0;
        o_busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_PREAMBLE, ST_SYNC, ST_PAYLOAD: begin
                o_bit_valid = 1'b1;
                o_bit       = sh_msb;
            end
            ST_FETCH: begin
                o_rd       = 1'b1;
                o_ram_addr = idx_q;
            end
            ST_CW: begin
                o_cw_en     = 1'b1;
                o_bit_valid = (len_q != '0);
                o_bit       = (len_q != '0);
            end
            ST_DONE: o_tx_done = (cnt_q == '0);
            default: ;
        endcase
    end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter PREAMBLE_BYTES, default 4, number of preamble bytes sent before the sync word.
REQ-002 Parameter PREAMBLE_BYTE, default 8'hAA, preamble byte value.
REQ-003 Parameter SYNC_WORD, default 16'h2DD4, sync word sent after the preamble, MSB first.
REQ-004 Parameter RAM_DEPTH, default 1000, highest payload length in bytes; longer requests are clamped to this value.
REQ-005 The ports SHALL be:
- clk, input, 1 bit: the single clock; all logic is on its rising edge.
- reset, input, 1 bit: synchronous, active-high reset.
- i_transmit, input, 1 bit: transmit request level from the register block.
- i_msg_length, input, 10 bits: payload length in bytes.
- i_reg_cw, input, 1 bit: continuous-wave mode select.
- i_ram_data, input, 8 bits: message RAM read data, valid 1 cycle after o_rd.
- o_rd, output, 1 bit: message RAM read strobe.
- o_ram_addr, output, 10 bits: message RAM read address.
- o_bit, output, 1 bit: serial bit to the modulator.
- o_bit_valid, output, 1 bit: o_bit is valid.
- i_bit_ready, input, 1 bit: the modulator accepts the bit.
- o_cw_en, output, 1 bit: modulator outputs an unmodulated carrier.
- o_busy, output, 1 bit: a frame or CW burst is in progress.
- o_tx_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-006 The FSM SHALL have the states IDLE, PREAMBLE, SYNC, FETCH, LOAD, PAYLOAD, CW and DONE.
REQ-007 In IDLE with i_transmit=1, the block SHALL latch len = min(i_msg_length, RAM_DEPTH) and latch i_reg_cw, then go next cycle:
- to CW if the latched cw bit = 1;
- otherwise to PREAMBLE.
REQ-008 A bit transfer SHALL occur only on a cycle with o_bit_valid=1 and i_bit_ready=1.
REQ-009 While o_bit_valid=1, o_bit SHALL stay stable until the transfer; o_bit_valid SHALL NOT drop without a transfer.
REQ-010 Bits SHALL be sent MSB first.
REQ-011 PREAMBLE SHALL send PREAMBLE_BYTES x 8 bits of PREAMBLE_BYTE.
REQ-012 SYNC SHALL send the 16 bits of SYNC_WORD.
REQ-013 After the last sync bit transfers, the FSM SHALL go to FETCH if len>0, else to DONE.
REQ-014 FETCH SHALL last one cycle: o_rd=1, o_ram_addr=byte index (0..len-1), o_bit_valid=0.
REQ-015 LOAD SHALL last one cycle: i_ram_data is captured into the shifter, o_bit_valid=0.
REQ-016 PAYLOAD SHALL send the 8 bits of the shifter.
REQ-017 When the 8th payload bit transfers:
- the byte index increments;
- the FSM goes to FETCH if index<len, else to DONE.
REQ-018 CW SHALL assert o_cw_en=1 and o_bit_valid=1 with o_bit=1 for len x 8 transfers, then go to DONE.
REQ-019 In CW with len=0, the FSM SHALL go directly to DONE.
REQ-020 On entering DONE, o_tx_done SHALL pulse for exactly 1 cycle.
REQ-021 DONE SHALL then wait until i_transmit=0 before returning to IDLE, so the still-high request cannot retrigger.
REQ-022 o_busy SHALL be 1 in every state except IDLE.
REQ-023 After the start, changes on i_transmit, i_msg_length and i_reg_cw SHALL be ignored until DONE.
REQ-024 o_rd SHALL be asserted only in FETCH.
REQ-025 o_ram_addr SHALL never exceed RAM_DEPTH-1 when o_rd=1.
REQ-026 Bit counters SHALL be sized so that 1000 x 8 transfers do not wrap.

Reset
REQ-027 On reset=1 at a clock edge the block SHALL, on the next cycle:
- be in IDLE;
- drive o_rd, o_bit, o_bit_valid, o_cw_en, o_busy and o_tx_done to 0, and o_ram_addr to 0;
- clear all counters.
REQ-028 Reset mid-frame SHALL abort without a o_tx_done pulse.
REQ-029 After reset, a new frame SHALL start only on i_transmit=1 seen in IDLE.

Structure
REQ-030 The state encoding, the default PREAMBLE_BYTE and SYNC_WORD values and RAM_DEPTH SHALL be defined in a shared package, modem_pkg.
REQ-031 A single sub-module, bit_shifter, is natural: an 8-bit parallel-load, MSB-first shift register with a load strobe and a shift strobe, used by all bit-sending states.

Verification
REQ-032 i_msg_length=2, RAM[0]=8'h5A, RAM[1]=8'hC3, i_bit_ready held 1: the bench SHALL see exactly 32 preamble bits of 0xAA, then 0x2DD4, then 0x5A then 0xC3 (MSB first), then one o_tx_done pulse.
REQ-033 i_bit_ready toggling at random, with i_msg_length=1: o_bit SHALL stay stable while valid and not ready, and the same bit sequence SHALL result.
REQ-034 i_msg_length=0: only preamble and sync SHALL be sent, with o_rd never asserted, then o_tx_done pulses.
REQ-035 i_reg_cw=1, i_msg_length=3: 24 transfers with o_cw_en=1 and o_bit=1, o_rd never asserted, then o_tx_done.
REQ-036 i_transmit held high 2 cycles after o_tx_done, then 10 more cycles: no second frame SHALL start; i_msg_length=1023 SHALL clamp to 1000 bytes, with last address 999.
REQ-037 reset asserted during the 5th payload byte: all outputs SHALL be 0 the next cycle, no o_tx_done pulse, and the FSM in IDLE.
